// File: rtl/fisr_init_stage.sv
// rtl/fisr_init_stage.sv - classify single-precision operands and form y0 / x-half seeds for 1/sqrt
module fisr_init_stage #(
    parameter logic [31:0] MAGIC = 32'h5F3759DF,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             s_tlast,
    output logic [31:0]      m_y0,
    output logic [31:0]      m_xhalf,
    output logic             m_special,
    output logic             m_tlast,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [CNT_W-1:0] special_cnt
);

    typedef enum logic [2:0] {
        CL_NORMAL,
        CL_ZERO,
        CL_LOW,
        CL_NEG,
        CL_INF,
        CL_NAN
    } op_class_t;

    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    op_class_t   in_class;
    op_class_t   class1;
    logic [31:0] x1;
    logic        last1;
    logic        v1;
    logic        v2;
    logic        adv1;
    logic        adv2;
    logic [31:0] y0_next;
    logic [31:0] xhalf_next;
    logic        special_next;

    assign adv2     = ~v2 | m_tready;
    assign adv1     = ~v1 | adv2;
    assign s_tready = adv1;
    assign m_tvalid = v2;

    // NaN must be tested before zero/sign so that negative NaNs stay NaN
    always_comb begin
        in_class = CL_NORMAL;
        if (s_tdata[30:23] == 8'hFF && s_tdata[22:0] != 23'd0) begin
            in_class = CL_NAN;
        end else if (s_tdata[30:23] == 8'h00) begin
            in_class = CL_ZERO;
        end else if (s_tdata[31]) begin
            in_class = CL_NEG;
        end else if (s_tdata[30:23] == 8'hFF) begin
            in_class = CL_INF;
        end else if (s_tdata[30:23] == 8'h01) begin
            in_class = CL_LOW;
        end
    end

    always_comb begin
        y0_next      = 32'd0;
        xhalf_next   = 32'd0;
        special_next = 1'b1;
        case (class1)
            CL_NORMAL: begin
                y0_next      = MAGIC - {1'b0, x1[31:1]};
                xhalf_next   = {1'b0, x1[30:23] - 8'd1, x1[22:0]};
                special_next = 1'b0;
            end
            CL_ZERO, CL_LOW: y0_next = POS_INF;
            CL_NEG, CL_NAN:  y0_next = QNAN;
            default:         y0_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            x1     <= 32'd0;
            last1  <= 1'b0;
            class1 <= CL_NORMAL;
        end else if (adv1) begin
            v1 <= s_tvalid;
            if (s_tvalid) begin
                x1     <= s_tdata;
                last1  <= s_tlast;
                class1 <= in_class;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2        <= 1'b0;
            m_y0      <= 32'd0;
            m_xhalf   <= 32'd0;
            m_special <= 1'b0;
            m_tlast   <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                m_y0      <= y0_next;
                m_xhalf   <= xhalf_next;
                m_special <= special_next;
                m_tlast   <= last1;
            end
        end
    end

    // Counted at acceptance, so stalled or later-flushed specials still count
    always_ff @(posedge clk) begin
        if (rst) begin
            special_cnt <= '0;
        end else if (s_tvalid && adv1 && in_class != CL_NORMAL && special_cnt != {CNT_W{1'b1}}) begin
            special_cnt <= special_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
